ex_mem: RTL
===========

// Module: ex_mem
// PURPOSE
//   EX->MEM pipeline register. Latches the EX-stage result (write-back target, ALU data,
//   HI/LO update, load/store info) and presents it to the MEM stage on the next cycle.
//   Handles pipeline stall (hold or bubble) and flush.
//   Carries the multi-cycle accumulate state (hilo_o, cnt_o) back to EX while EX is stalled.
// PARAMETERS
//   DW     32  data width (reg, HI, LO, address)
//   AW     5   register-file address width
//   OPW    8   ALU opcode width (matches AluOpBus)
// PORTS
//   clk          in   1     rising-edge clock
//   rst          in   1     reset, synchronous, active-low (0 = reset)
//   stall        in   6     stall vector; [2]=EX stalled, [3]=MEM stalled
//   flush        in   1     exception flush; invalidates this stage
//   ex_wd        in   AW    dest register from EX
//   ex_wreg      in   1     write-enable from EX
//   ex_wdata     in   DW    result data from EX
//   ex_hi        in   DW    HI value from EX
//   ex_lo        in   DW    LO value from EX
//   ex_whilo     in   1     HI/LO write-enable from EX
//   ex_aluop     in   OPW   opcode (MEM decodes load/store)
//   ex_mem_addr  in   DW    effective load/store address
//   ex_reg2      in   DW    store data
//   hilo_i       in   2*DW  partial product from EX (multi-cycle MADD/MSUB)
//   cnt_i        in   2     EX multi-cycle step counter
//   mem_wd       out  AW    registered ex_wd
//   mem_wreg     out  1     registered ex_wreg
//   mem_wdata    out  DW    registered ex_wdata
//   mem_hi       out  DW    registered ex_hi
//   mem_lo       out  DW    registered ex_lo
//   mem_whilo    out  1     registered ex_whilo
//   mem_aluop    out  OPW   registered ex_aluop
//   mem_mem_addr out  DW    registered ex_mem_addr
//   mem_reg2     out  DW    registered ex_reg2
//   hilo_o       out  2*DW  partial product returned to EX
//   cnt_o        out  2     step counter returned to EX
// BEHAVIOUR
//   - All outputs registered; update only on rising clk; latency EX->MEM = 1 cycle.
//   - Per-edge priority, highest first; exactly one row applies:
//     1 RESET (rst==0): all outputs <= 0. Applies mid-operation; drops any held state.
//     2 FLUSH (flush==1): all mem_* <= 0 (bubble). hilo_o <= 0, cnt_o <= 0.
//     3 BUBBLE (stall[2]==1 && stall[3]==0): all mem_* <= 0, so MEM receives a NOP.
//         hilo_o <= hilo_i, cnt_o <= cnt_i, so EX keeps its accumulation step.
//     4 HOLD (stall[2]==1 && stall[3]==1): every output keeps its value.
//     5 CAPTURE (stall[2]==0): every mem_* <= its ex_* input. hilo_o <= 0, cnt_o <= 0.
//   - Bubble = all mem_* zero. Consequences: wreg=0, whilo=0, aluop=NOP.
//     MEM performs no access and no write-back.
//   - stall[2]==0 with stall[3]==1 is illegal (upstream controller never drives it).
//     Bench asserts it never occurs. RTL treats it as CAPTURE.
//   - Outputs are pure register values; no combinational input->output path.
// TESTING
//   T1 reset: rst=0 one cycle, inputs all-ones -> every output 0 next cycle.
//   T2 capture: rst=1, stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0x1234_5678
//      -> next cycle mem_wd=5, mem_wreg=1, mem_wdata=0x1234_5678.
//   T3 bubble: stall=6'b000100, ex_wreg=1, hilo_i=64'hA, cnt_i=1
//      -> mem_wreg=0, mem_wdata=0, hilo_o=64'hA, cnt_o=1.
//      Then stall=0, ex_wdata=0x55 -> mem_wdata=0x55, hilo_o=0, cnt_o=0.
//   T4 hold: capture ex_wdata=0x99, then stall=6'b001100 for 3 cycles with new inputs
//      -> mem_wdata stays 0x99 all 3 cycles.
//   T5 flush priority: flush=1, stall=6'b001100, ex_wreg=1 -> all mem_*=0, cnt_o=0.
//   T6 reset mid-stall: during hold with mem_wdata=0x99, assert rst=0
//      -> all outputs 0. After rst=1 with stall=0, next capture passes through normally.

Source files
------------

// File: rtl/ex_mem_if.sv
// EX->MEM pipeline bus: EX-side result fields, MEM-side registered copies,
// and the multi-cycle accumulate state that loops back to EX.
interface ex_mem_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 8
);
    logic [AW-1:0]   ex_wd;
    logic            ex_wreg;
    logic [DW-1:0]   ex_wdata;
    logic [DW-1:0]   ex_hi;
    logic [DW-1:0]   ex_lo;
    logic            ex_whilo;
    logic [OPW-1:0]  ex_aluop;
    logic [DW-1:0]   ex_mem_addr;
    logic [DW-1:0]   ex_reg2;
    logic [2*DW-1:0] hilo_i;
    logic [1:0]      cnt_i;

    logic [AW-1:0]   mem_wd;
    logic            mem_wreg;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_hi;
    logic [DW-1:0]   mem_lo;
    logic            mem_whilo;
    logic [OPW-1:0]  mem_aluop;
    logic [DW-1:0]   mem_mem_addr;
    logic [DW-1:0]   mem_reg2;
    logic [2*DW-1:0] hilo_o;
    logic [1:0]      cnt_o;

    modport master (
        output ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
               ex_mem_addr, ex_reg2, hilo_i, cnt_i,
        input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
               mem_mem_addr, mem_reg2, hilo_o, cnt_o
    );

    modport slave (
        input  ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
               ex_mem_addr, ex_reg2, hilo_i, cnt_i,
        output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
               mem_mem_addr, mem_reg2, hilo_o, cnt_o
    );
endinterface

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall hold/bubble, flush, and loop-back of the
// multi-cycle accumulate state (hilo/cnt) to EX while EX is stalled.
module ex_mem #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] stall,
    input  logic       flush,
    ex_mem_if.slave    bus
);

    logic [AW-1:0]   wd_q;
    logic            wreg_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   hi_q;
    logic [DW-1:0]   lo_q;
    logic            whilo_q;
    logic [OPW-1:0]  aluop_q;
    logic [DW-1:0]   mem_addr_q;
    logic [DW-1:0]   reg2_q;
    logic [2*DW-1:0] hilo_q;
    logic [1:0]      cnt_q;

    logic ex_stall;
    logic mem_stall;
    logic unused_stall_bits;

    assign ex_stall          = stall[2];
    assign mem_stall         = stall[3];
    assign unused_stall_bits = ^{stall[5:4], stall[1:0]};

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            wdata_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            whilo_q    <= 1'b0;
            aluop_q    <= '0;
            mem_addr_q <= '0;
            reg2_q     <= '0;
            hilo_q     <= '0;
            cnt_q      <= 2'd0;
        end else if (ex_stall && !mem_stall) begin
            // MEM sees a NOP while EX keeps its partial product for the next step
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            wdata_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            whilo_q    <= 1'b0;
            aluop_q    <= '0;
            mem_addr_q <= '0;
            reg2_q     <= '0;
            hilo_q     <= bus.hilo_i;
            cnt_q      <= bus.cnt_i;
        end else if (!ex_stall) begin
            // the illegal EX-running/MEM-stalled combination also lands here
            wd_q       <= bus.ex_wd;
            wreg_q     <= bus.ex_wreg;
            wdata_q    <= bus.ex_wdata;
            hi_q       <= bus.ex_hi;
            lo_q       <= bus.ex_lo;
            whilo_q    <= bus.ex_whilo;
            aluop_q    <= bus.ex_aluop;
            mem_addr_q <= bus.ex_mem_addr;
            reg2_q     <= bus.ex_reg2;
            hilo_q     <= '0;
            cnt_q      <= 2'd0;
        end
    end

    assign bus.mem_wd       = wd_q;
    assign bus.mem_wreg     = wreg_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_hi       = hi_q;
    assign bus.mem_lo       = lo_q;
    assign bus.mem_whilo    = whilo_q;
    assign bus.mem_aluop    = aluop_q;
    assign bus.mem_mem_addr = mem_addr_q;
    assign bus.mem_reg2     = reg2_q;
    assign bus.hilo_o       = hilo_q;
    assign bus.cnt_o        = cnt_q;

endmodule
